// File: rtl/event_encoder8_pkg.sv
// Shared constants and FSM encoding for the eight-line event encoder.
package event_encoder8_pkg;

  localparam int unsigned NUM_LINES = 8;
  localparam int unsigned IDX_W     = 3;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/event_encoder8_prio_enc8.sv
// Fixed-priority selector: returns the index of the winning request bit.
module prio_enc8
  import event_encoder8_pkg::*;
#(
  parameter bit PRIORITY_HIGH = 1'b1
) (
  input  logic [NUM_LINES-1:0] req,
  output logic [IDX_W-1:0]     idx,
  output logic                 any
);

  // Last assignment in scan order wins, so scan from lowest to highest priority.
  always_comb begin
    idx = '0;
    any = |req;
    if (PRIORITY_HIGH) begin
      for (int i = 0; i < int'(NUM_LINES); i++) begin
        if (req[i]) idx = IDX_W'(i);
      end
    end else begin
      for (int i = int'(NUM_LINES) - 1; i >= 0; i--) begin
        if (req[i]) idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/event_encoder8.sv
// Edge-detects eight event lines, queues them as pending bits and hands
// encoded line indices to a valid/ready consumer one at a time.
module event_encoder8
  import event_encoder8_pkg::*;
#(
  parameter bit PRIORITY_HIGH = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d0,
  input  logic d1,
  input  logic d2,
  input  logic d3,
  input  logic d4,
  input  logic d5,
  input  logic d6,
  input  logic d7,
  input  logic ready,
  output logic a,
  output logic b,
  output logic c,
  output logic valid,
  output logic overflow
);

  logic [NUM_LINES-1:0] d_vec;
  logic [NUM_LINES-1:0] d_q;
  logic [NUM_LINES-1:0] mask_q;
  logic [NUM_LINES-1:0] edges_c;
  logic [NUM_LINES-1:0] pending;
  logic [NUM_LINES-1:0] pending_nxt;
  logic [NUM_LINES-1:0] clr_c;
  logic [IDX_W-1:0]     sel_idx;
  logic                 sel_any;
  logic                 load_c;
  logic                 ovf_set_c;
  logic [IDX_W-1:0]     code_q;
  logic [IDX_W-1:0]     code_nxt;
  logic                 valid_q;
  logic                 overflow_q;
  state_t               state;
  state_t               state_nxt;

  assign d_vec = {d7, d6, d5, d4, d3, d2, d1, d0};

  // mask_q holds the levels seen at the last reset edge so lines already high
  // when reset releases are not mistaken for fresh events.
  assign edges_c = d_vec & ~d_q & ~mask_q;

  prio_enc8 #(.PRIORITY_HIGH(PRIORITY_HIGH)) u_prio (
    .req (pending),
    .idx (sel_idx),
    .any (sel_any)
  );

  // Next-state, pending update and overflow detection.
  always_comb begin
    state_nxt   = state;
    code_nxt    = code_q;
    load_c      = sel_any && ((state == ST_EMPTY) || ready);
    clr_c       = load_c ? (NUM_LINES'(1) << sel_idx) : '0;
    pending_nxt = (pending & ~clr_c) | edges_c;
    ovf_set_c   = |(edges_c & pending & ~clr_c);
    case (state)
      ST_EMPTY: begin
        if (load_c) begin
          state_nxt = ST_FULL;
          code_nxt  = sel_idx;
        end
      end
      ST_FULL: begin
        if (load_c) begin
          code_nxt = sel_idx;
        end else if (ready) begin
          state_nxt = ST_EMPTY;
          code_nxt  = '0;
        end
      end
      default: begin
        state_nxt = ST_EMPTY;
        code_nxt  = '0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_EMPTY;
    else       state <= state_nxt;
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      d_q        <= '0;
      mask_q     <= d_vec;
      pending    <= '0;
      code_q     <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      d_q        <= d_vec;
      mask_q     <= '0;
      pending    <= pending_nxt;
      code_q     <= code_nxt;
      valid_q    <= (state_nxt == ST_FULL);
      overflow_q <= overflow_q | ovf_set_c;
    end
  end

  assign a        = code_q[2];
  assign b        = code_q[1];
  assign c        = code_q[0];
  assign valid    = valid_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_event_encoder8.sv
// Bench for event_encoder8: directed scenarios plus random traffic against a
// line-by-line behavioural model.
module tb_event_encoder8;

  localparam bit PH = 1'b1;

  logic       clk = 1'b0;
  logic       reset;
  logic       ready;
  logic [7:0] d;
  logic       a, b, c, valid, overflow;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  bit m_pend[8];
  bit m_prev[8];
  bit m_valid;
  bit m_ovf;
  int m_code;

  always #5 clk = ~clk;

  event_encoder8 #(.PRIORITY_HIGH(PH)) dut (
    .clk      (clk),
    .reset    (reset),
    .d0       (d[0]),
    .d1       (d[1]),
    .d2       (d[2]),
    .d3       (d[3]),
    .d4       (d[4]),
    .d5       (d[5]),
    .d6       (d[6]),
    .d7       (d[7]),
    .ready    (ready),
    .a        (a),
    .b        (b),
    .c        (c),
    .valid    (valid),
    .overflow (overflow)
  );

  function automatic void model_step(bit r, logic [7:0] dv, bit rd);
    int pick;
    if (r) begin
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      foreach (m_prev[i]) m_prev[i] = dv[i];
      m_valid = 1'b0;
      m_code  = 0;
      m_ovf   = 1'b0;
      return;
    end
    pick = -1;
    if (!m_valid || rd) begin
      for (int k = 0; k < 8; k++) begin
        int i;
        i = PH ? 7 - k : k;
        if (m_pend[i] && pick < 0) pick = i;
      end
    end
    if (pick >= 0) m_pend[pick] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (dv[i] && !m_prev[i]) begin
        if (m_pend[i]) m_ovf = 1'b1;
        m_pend[i] = 1'b1;
      end
      m_prev[i] = dv[i];
    end
    if (pick >= 0) begin
      m_valid = 1'b1;
      m_code  = pick;
    end else if (rd) begin
      m_valid = 1'b0;
      m_code  = 0;
    end
  endfunction

  task automatic tick();
    bit r, rd;
    logic [7:0] dv;
    r  = reset;
    rd = ready;
    dv = d;
    @(posedge clk);
    model_step(r, dv, rd);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    d     = '0;
    ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    d     = 8'hFF;
    ready = 1'b1;
    tick();
    tick();
    checks++;
    if ({valid, a, b, c, overflow} !== 5'b0) begin
      errors++;
      $display("FAIL reset_state: valid,abc,ovf=%b want 00000", {valid, a, b, c, overflow});
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({valid, a, b, c} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_held_high cyc%0d: valid,abc=%b want 0000", i, {valid, a, b, c});
      end
    end
    d = '0;
  endtask

  task automatic test_single();
    do_reset();
    ready = 1'b1;
    tick();
    d[5] = 1'b1;
    tick();
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL single_n1: valid=%b want 0", valid);
    end
    tick();
    checks++;
    if ({valid, a, b, c} !== 4'b1101) begin
      errors++;
      $display("FAIL single_n2: valid,abc=%b want 1101", {valid, a, b, c});
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({valid, a, b, c} !== 4'b0000) begin
        errors++;
        $display("FAIL single_after cyc%0d: valid,abc=%b want 0000", i, {valid, a, b, c});
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] exp [4];
    exp[0] = 4'b1110;
    exp[1] = 4'b1011;
    exp[2] = 4'b1001;
    exp[3] = 4'b0000;
    do_reset();
    ready = 1'b1;
    d = 8'b0100_1010;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({valid, a, b, c} !== exp[i]) begin
        errors++;
        $display("FAIL simultaneous step%0d: valid,abc=%b want %b", i, {valid, a, b, c}, exp[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    d[2] = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ({valid, a, b, c} !== 4'b1010) begin
        errors++;
        $display("FAIL backpressure hold%0d: valid,abc=%b want 1010", i, {valid, a, b, c});
      end
      if (i < 5) tick();
    end
    ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({valid, a, b, c} !== 4'b0000) begin
        errors++;
        $display("FAIL backpressure accept%0d: valid,abc=%b want 0000", i, {valid, a, b, c});
      end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    d[7] = 1'b1;
    tick();
    tick();
    d[4] = 1'b1; tick();
    d[4] = 1'b0; tick();
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow_first_pulse: overflow=%b want 0", overflow);
    end
    d[4] = 1'b1; tick();
    checks++;
    if ({overflow, valid, a, b, c} !== 5'b11111) begin
      errors++;
      $display("FAIL overflow_set: ovf,valid,abc=%b want 11111", {overflow, valid, a, b, c});
    end
    d[4] = 1'b0;
    ready = 1'b1;
    tick();
    checks++;
    if ({valid, a, b, c} !== 4'b1100) begin
      errors++;
      $display("FAIL overflow_emit: valid,abc=%b want 1100", {valid, a, b, c});
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({overflow, valid} !== 2'b10) begin
        errors++;
        $display("FAIL overflow_sticky cyc%0d: ovf,valid=%b want 10", i, {overflow, valid});
      end
    end
  endtask

  task automatic test_coincident();
    do_reset();
    d[7] = 1'b1;
    tick();
    tick();
    d[0] = 1'b1; tick();
    d[0] = 1'b0; tick();
    d[0] = 1'b1;
    ready = 1'b1;
    tick();
    checks++;
    if ({valid, a, b, c} !== 4'b1000) begin
      errors++;
      $display("FAIL coincident_first: valid,abc=%b want 1000", {valid, a, b, c});
    end
    tick();
    checks++;
    if ({valid, a, b, c} !== 4'b1000) begin
      errors++;
      $display("FAIL coincident_second: valid,abc=%b want 1000", {valid, a, b, c});
    end
    tick();
    checks++;
    if ({overflow, valid} !== 2'b00) begin
      errors++;
      $display("FAIL coincident_end: ovf,valid=%b want 00", {overflow, valid});
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    d[5] = 1'b1;
    tick();
    tick();
    d[7] = 1'b1;
    d[4] = 1'b1;
    tick();
    checks++;
    if ({valid, a, b, c} !== 4'b1101) begin
      errors++;
      $display("FAIL reset_mid_pre: valid,abc=%b want 1101", {valid, a, b, c});
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({valid, a, b, c, overflow} !== 5'b0) begin
      errors++;
      $display("FAIL reset_mid_cleared: valid,abc,ovf=%b want 00000", {valid, a, b, c, overflow});
    end
    reset = 1'b0;
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({valid, a, b, c} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_mid_quiet cyc%0d: valid,abc=%b want 0000", i, {valid, a, b, c});
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      reset = ($urandom_range(0, 149) == 0);
      ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 8; i++) begin
        if ($urandom_range(0, 4) == 0) d[i] = ~d[i];
      end
      tick();
      checks++;
      if ({valid, a, b, c, overflow} !== {m_valid, 3'(m_code), m_ovf}) begin
        errors++;
        $display("FAIL random cyc%0d: valid,abc,ovf=%b want %b", n,
                 {valid, a, b, c, overflow}, {m_valid, 3'(m_code), m_ovf});
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    ready = 1'b0;
    d     = '0;
    test_reset();
    test_single();
    test_simultaneous();
    test_backpressure();
    test_overflow();
    test_coincident();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/event_encoder8.md
EVENT_ENCODER8 -- requirements
Module: event_encoder8

Interface
REQ-001 SHALL have parameter PRIORITY_HIGH, default 1, meaning 1 = d7 highest priority and 0 = d0 highest priority.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; every register is updated on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-004 SHALL have ports d0..d7, input, 1 bit each: level event lines; a rising edge on a line is one event.
REQ-005 SHALL have ports a, b, c, output, 1 bit each: the encoded line index {a,b,c}, with a as MSB (d5 encodes as a=1 b=0 c=1).
REQ-006 SHALL have port valid, output, 1 bit: {a,b,c} holds an event awaiting acceptance.
REQ-007 SHALL have port ready, input, 1 bit: the consumer accepts the code in any cycle where valid && ready.
REQ-008 SHALL have port overflow, output, 1 bit: sticky flag meaning an event was lost.

Function
REQ-009 SHALL register d0..d7 into d_q[7:0] every cycle.
REQ-010 SHALL define edge[i] = d_i && !d_q[i], evaluated combinationally in the cycle it occurs.
REQ-011 SHALL hold an 8-bit pending register; edge[i] in cycle n sets pending[i] at the end of cycle n.
REQ-012 SHALL use a two-state output FSM: EMPTY (valid=0) and FULL (valid=1).
REQ-013 SHALL define load = (pending != 0) && (state==EMPTY || ready).
REQ-014 SHALL, on load, choose the selected line by fixed priority among set pending bits, following PRIORITY_HIGH.
REQ-015 SHALL, on load, register the selected line's index into {a,b,c}, clear its pending bit, and leave or stay in FULL.
REQ-016 SHALL move FULL -> EMPTY when valid && ready && pending==0.
REQ-017 SHALL hold {a,b,c} and valid stable while valid && !ready.
REQ-018 SHALL give a latency of 2 cycles from an edge in cycle n to valid=1 in cycle n+2, with the slot empty and no higher-priority pending.
REQ-019 SHALL sustain one code per cycle while ready=1 and pending is non-zero (back-to-back).
REQ-020 SHALL, when edge[i] coincides with the load that clears pending[i], leave pending[i] set: the new event is kept.
REQ-021 SHALL set overflow when edge[i] occurs while pending[i]=1 and pending[i] is not being cleared that cycle; that event is dropped.
REQ-022 SHALL keep overflow at 1 until reset.
REQ-023 SHALL treat simultaneous edges on several lines as separate events, emitted in priority order.
REQ-024 SHALL treat a line held high as one event; no re-trigger until it falls and rises again.
REQ-025 SHALL give {a,b,c} = 000 whenever valid=0.

Reset
REQ-026 SHALL, while reset=1 at a clock edge, clear pending, d_q, a, b, c, valid and overflow to 0 and force state to EMPTY.
REQ-027 SHALL ignore ready and d0..d7 in a cycle where reset=1.
REQ-028 SHALL discard any code in flight when reset is asserted mid-operation.
REQ-029 SHALL, after reset deasserts, not report a line that was already high as an event.

Structure
REQ-030 SHALL place the FSM state encoding (EMPTY, FULL) and the constant NUM_LINES = 8 in a shared package.
REQ-031 SHALL implement priority selection in one combinational sub-module, prio_enc8.
REQ-032 SHALL have prio_enc8 take an 8-bit request and PRIORITY_HIGH, and return a 3-bit index and an any flag.
REQ-033 SHALL hold everything else (edge detect, pending, FSM, output register) in event_encoder8.

Verification
REQ-034 SHALL cover a single event: d5 rises at cycle 10, ready=1 -> valid=1 with a,b,c = 1,0,1 at cycle 12 only.
REQ-035 SHALL cover simultaneous edges: d1, d3 and d6 rise together, ready=1, PRIORITY_HIGH=1 -> codes 110, 011, 001 on three consecutive cycles, then valid=0.
REQ-036 SHALL cover backpressure: d2 rises, ready=0 for 5 cycles -> a,b,c = 0,1,0 and valid held stable; ready=1 -> accepted once.
REQ-037 SHALL cover overflow: ready=0, d4 pulses twice with the slot FULL on another code -> overflow=1, d4 emitted once, overflow stays 1.
REQ-038 SHALL cover coincident re-edge: d0 re-rises in the cycle its pending bit loads -> code 000 emitted twice, overflow=0.
REQ-039 SHALL cover reset mid-stream: reset asserted with valid=1 and pending=0x90 -> next cycle valid=0, pending=0, overflow=0, and lines held high produce no code.
